// File: rtl/mux_scan_pkg.sv
// Shared constants and state type for the scan controller and its data bank.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mux_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/reg_bank_8.sv
// Eight-word register bank that drives the selector data inputs.
// Latency: a write at an edge is visible on o_d* immediately after that edge.
// Backpressure: none; every write is accepted.
module reg_bank_8
    import mux_scan_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [SEL_W-1:0] i_waddr,
    input  logic [N-1:0]     i_wdata,
    output logic [N-1:0]     o_d0,
    output logic [N-1:0]     o_d1,
    output logic [N-1:0]     o_d2,
    output logic [N-1:0]     o_d3,
    output logic [N-1:0]     o_d4,
    output logic [N-1:0]     o_d5,
    output logic [N-1:0]     o_d6,
    output logic [N-1:0]     o_d7
);

    logic [N-1:0] r_mem [NUM_CH];

    // Single write port; the whole bank clears on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_d0 = r_mem[0];
    assign o_d1 = r_mem[1];
    assign o_d2 = r_mem[2];
    assign o_d3 = r_mem[3];
    assign o_d4 = r_mem[4];
    assign o_d5 = r_mem[5];
    assign o_d6 = r_mem[6];
    assign o_d7 = r_mem[7];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the 8:1 selector through channels 0..7 and captures z_in at the end of each dwell.
// Latency: channel k captured at edge t0+(k+1)*DWELL; sample_valid/done high the following cycle.
// Backpressure: none; samples are one-cycle pulses and must be taken when presented.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int N     = 4,
    parameter int DWELL = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_cont,
    input  logic             i_we,
    input  logic [SEL_W-1:0] i_waddr,
    input  logic [N-1:0]     i_wdata,
    output logic [N-1:0]     o_d0,
    output logic [N-1:0]     o_d1,
    output logic [N-1:0]     o_d2,
    output logic [N-1:0]     o_d3,
    output logic [N-1:0]     o_d4,
    output logic [N-1:0]     o_d5,
    output logic [N-1:0]     o_d6,
    output logic [N-1:0]     o_d7,
    output logic [SEL_W-1:0] o_s,
    input  logic [N-1:0]     i_z_in,
    output logic [N-1:0]     o_sample,
    output logic [SEL_W-1:0] o_sample_ch,
    output logic             o_sample_valid,
    output logic             o_busy,
    output logic             o_done
);

    localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]  CH_LAST  = SEL_W'(NUM_CH - 1);

    state_t           r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [SEL_W-1:0] r_s,      w_s_nxt;
    logic [N-1:0]     r_sample, w_sample_nxt;
    logic [SEL_W-1:0] r_ch,     w_ch_nxt;
    logic             r_vld,    w_vld_nxt;
    logic             r_busy,   w_busy_nxt;
    logic             r_done,   w_done_nxt;
    logic             r_cont,   w_cont_nxt;

    reg_bank_8 #(.N(N)) u_bank (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (i_we),
        .i_waddr (i_waddr),
        .i_wdata (i_wdata),
        .o_d0    (o_d0),
        .o_d1    (o_d1),
        .o_d2    (o_d2),
        .o_d3    (o_d3),
        .o_d4    (o_d4),
        .o_d5    (o_d5),
        .o_d6    (o_d6),
        .o_d7    (o_d7)
    );

    // Register all controller state and outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_s      <= '0;
            r_sample <= '0;
            r_ch     <= '0;
            r_vld    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cont   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_s      <= w_s_nxt;
            r_sample <= w_sample_nxt;
            r_ch     <= w_ch_nxt;
            r_vld    <= w_vld_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_cont   <= w_cont_nxt;
        end
    end

    // Next state: dwell counting, channel stepping, capture; stop overrides a capture.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_s_nxt      = r_s;
        w_sample_nxt = r_sample;
        w_ch_nxt     = r_ch;
        w_vld_nxt    = 1'b0;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_cont_nxt   = r_cont;
        case (r_state)
            IDLE: begin
                w_cnt_nxt  = '0;
                w_s_nxt    = '0;
                w_busy_nxt = 1'b0;
                if (i_start && !i_stop) begin
                    w_state_nxt = RUN;
                    w_busy_nxt  = 1'b1;
                    w_cont_nxt  = i_cont;
                end
            end
            RUN: begin
                if (i_stop) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_s_nxt     = '0;
                    w_busy_nxt  = 1'b0;
                end else if (r_cnt == CNT_LAST) begin
                    // z_in still reflects pre-write bank contents at this edge.
                    w_sample_nxt = i_z_in;
                    w_ch_nxt     = r_s;
                    w_vld_nxt    = 1'b1;
                    w_cnt_nxt    = '0;
                    w_s_nxt      = r_s + 1'b1;
                    if (!r_cont && (r_s == CH_LAST)) begin
                        w_state_nxt = IDLE;
                        w_s_nxt     = '0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_s            = r_s;
    assign o_sample       = r_sample;
    assign o_sample_ch    = r_ch;
    assign o_sample_valid = r_vld;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: one DWELL=4 and one DWELL=1 instance on shared stimulus.
// Latency: outputs compared 1ns after every rising edge against a time-based model.
// Backpressure: n/a.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, cont = 1'b0, we = 1'b0;
    logic [2:0] waddr = '0;
    logic [3:0] wdata = '0;

    logic [3:0] d_a   [2][8];
    logic [2:0] s_a   [2];
    logic [3:0] z_a   [2];
    logic [3:0] smp_a [2];
    logic [2:0] ch_a  [2];
    logic       vld_a [2];
    logic       busy_a[2];
    logic       done_a[2];

    int n_vec = 0;
    int n_err = 0;
    int pulses [2];
    int busy_cyc [2];

    // Reference model: scan described as elapsed cycles since start.
    logic       m_run  [2];
    int         m_el   [2];
    logic       m_cont [2];
    logic       m_vld  [2];
    logic       m_done [2];
    logic [3:0] m_smp  [2];
    logic [2:0] m_ch   [2];
    logic [3:0] m_bank [8];

    always #5 clk = ~clk;

    // Behavioural 8:1 selector feeding each controller.
    assign z_a[0] = d_a[0][s_a[0]];
    assign z_a[1] = d_a[1][s_a[1]];

    mux_scan_ctrl #(.N(4), .DWELL(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_cont(cont),
        .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .o_d0(d_a[0][0]), .o_d1(d_a[0][1]), .o_d2(d_a[0][2]), .o_d3(d_a[0][3]),
        .o_d4(d_a[0][4]), .o_d5(d_a[0][5]), .o_d6(d_a[0][6]), .o_d7(d_a[0][7]),
        .o_s(s_a[0]), .i_z_in(z_a[0]), .o_sample(smp_a[0]), .o_sample_ch(ch_a[0]),
        .o_sample_valid(vld_a[0]), .o_busy(busy_a[0]), .o_done(done_a[0])
    );

    mux_scan_ctrl #(.N(4), .DWELL(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_cont(cont),
        .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .o_d0(d_a[1][0]), .o_d1(d_a[1][1]), .o_d2(d_a[1][2]), .o_d3(d_a[1][3]),
        .o_d4(d_a[1][4]), .o_d5(d_a[1][5]), .o_d6(d_a[1][6]), .o_d7(d_a[1][7]),
        .o_s(s_a[1]), .i_z_in(z_a[1]), .o_sample(smp_a[1]), .o_sample_ch(ch_a[1]),
        .o_sample_valid(vld_a[1]), .o_busy(busy_a[1]), .o_done(done_a[1])
    );

    task automatic chk(input string tag, input int j, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", tag, j, act, exp, $time);
        end
    endtask

    function automatic int dwell_of(input int j);
        return (j == 0) ? 4 : 1;
    endfunction

    task automatic mdl_reset();
        for (int j = 0; j < 2; j++) begin
            m_run[j] = 1'b0; m_el[j] = 0; m_cont[j] = 1'b0;
            m_vld[j] = 1'b0; m_done[j] = 1'b0; m_smp[j] = '0; m_ch[j] = '0;
        end
        for (int k = 0; k < 8; k++) m_bank[k] = '0;
    endtask

    task automatic mdl_step(input int j);
        int dw;
        int ch;
        dw = dwell_of(j);
        m_vld[j]  = 1'b0;
        m_done[j] = 1'b0;
        if (m_run[j]) begin
            if (stop) begin
                m_run[j] = 1'b0;
                m_el[j]  = 0;
            end else begin
                m_el[j]++;
                if (m_el[j] % dw == 0) begin
                    ch = (m_el[j] / dw - 1) % 8;
                    m_smp[j] = m_bank[ch];
                    m_ch[j]  = ch[2:0];
                    m_vld[j] = 1'b1;
                    if (!m_cont[j] && m_el[j] == 8 * dw) begin
                        m_run[j]  = 1'b0;
                        m_done[j] = 1'b1;
                    end
                end
            end
        end else if (start && !stop) begin
            m_run[j]  = 1'b1;
            m_el[j]   = 0;
            m_cont[j] = cont;
        end
    endtask

    task automatic check_all(input int j);
        logic [31:0] bank_act, bank_exp;
        int exp_s;
        bank_act = '0;
        bank_exp = '0;
        for (int k = 0; k < 8; k++) begin
            bank_act[k*4 +: 4] = d_a[j][k];
            bank_exp[k*4 +: 4] = m_bank[k];
        end
        exp_s = m_run[j] ? (m_el[j] / dwell_of(j)) % 8 : 0;
        chk("busy",      j, 32'(busy_a[j]), 32'(m_run[j]));
        chk("s",         j, 32'(s_a[j]),    32'(exp_s));
        chk("valid",     j, 32'(vld_a[j]),  32'(m_vld[j]));
        chk("done",      j, 32'(done_a[j]), 32'(m_done[j]));
        chk("sample",    j, 32'(smp_a[j]),  32'(m_smp[j]));
        chk("sample_ch", j, 32'(ch_a[j]),   32'(m_ch[j]));
        chk("bank",      j, bank_act,       bank_exp);
    endtask

    task automatic step();
        @(posedge clk);
        mdl_step(0);
        mdl_step(1);
        if (we) m_bank[waddr] = wdata;
        #1;
        for (int j = 0; j < 2; j++) begin
            check_all(j);
            if (vld_a[j])  pulses[j]++;
            if (busy_a[j]) busy_cyc[j]++;
        end
    endtask

    task automatic drive(input logic st, input logic sp, input logic ct,
                         input logic w, input logic [2:0] wa, input logic [3:0] wd);
        start = st; stop = sp; cont = ct; we = w; waddr = wa; wdata = wd;
        step();
        start = 1'b0; stop = 1'b0; cont = 1'b0; we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        mdl_reset();
        pulses   = '{0, 0};
        busy_cyc = '{0, 0};
        #3;
        check_all(0);
        check_all(1);
        #9 rst_n = 1'b1;

        // Single pass, DWELL=4, bank d[k]=k+8.
        for (int k = 0; k < 8; k++) drive(0, 0, 0, 1, 3'(k), 4'(k + 8));
        pulses = '{0, 0}; busy_cyc = '{0, 0};
        drive(1, 0, 0, 0, 0, 0);
        idle(36);
        chk("pass_pulses", 0, 32'(pulses[0]), 32'd8);
        chk("pass_busy_cycles", 0, 32'(busy_cyc[0]), 32'd32);

        // Continuous, DWELL=1, bank d[k]=15-k, stop after 10 samples.
        for (int k = 0; k < 8; k++) drive(0, 0, 0, 1, 3'(k), 4'(15 - k));
        pulses = '{0, 0};
        drive(1, 0, 1, 0, 0, 0);
        idle(10);
        drive(0, 1, 0, 0, 0, 0);
        idle(5);
        chk("cont_pulses", 1, 32'(pulses[1]), 32'd10);

        // Write to d[2] mid-dwell: new value captured.
        drive(0, 0, 0, 1, 3'd2, 4'h3);
        drive(1, 0, 0, 0, 0, 0);
        idle(9);
        drive(0, 0, 0, 1, 3'd2, 4'hA);
        idle(2);
        chk("wr_mid_sample", 0, 32'(smp_a[0]), 32'hA);
        idle(25);

        // Write to d[2] on its capture edge: old value captured.
        drive(0, 0, 0, 1, 3'd2, 4'h3);
        drive(1, 0, 0, 0, 0, 0);
        idle(11);
        drive(0, 0, 0, 1, 3'd2, 4'hA);
        chk("wr_edge_sample", 0, 32'(smp_a[0]), 32'h3);
        chk("wr_edge_ch", 0, 32'(ch_a[0]), 32'd2);
        idle(25);

        // start+stop together in IDLE.
        drive(1, 1, 0, 0, 0, 0);
        chk("startstop_busy", 0, 32'(busy_a[0]), 32'd0);

        // stop coinciding with the ch0 capture edge.
        drive(1, 0, 0, 0, 0, 0);
        idle(3);
        drive(0, 1, 0, 0, 0, 0);
        idle(1);
        chk("stop_cap_valid", 0, 32'(vld_a[0]), 32'd0);

        // start while busy is ignored (cont stays single pass).
        drive(1, 0, 0, 0, 0, 0);
        idle(5);
        drive(1, 0, 1, 0, 0, 0);
        idle(30);

        // Reset mid-scan at s=3.
        drive(1, 0, 0, 0, 0, 0);
        idle(12);
        chk("s_before_reset", 0, 32'(s_a[0]), 32'd3);
        rst_n = 1'b0;
        #1;
        mdl_reset();
        check_all(0);
        check_all(1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(3);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom % 8) == 0, ($urandom % 24) == 0, 1'($urandom),
                  1'($urandom), 3'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
